// File: rtl/data_memory_block.sv
// Block-wide data memory behind the data cache: 128-bit block reads and writes
// with a fixed busy-wait latency, followed by one cool-down cycle.
module data_memory_block #(
  parameter int ADDR_W     = 28,
  parameter int BLOCK_W    = 128,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mem_Read,
  input  logic               mem_Write,
  input  logic [ADDR_W-1:0]  mem_Address,
  input  logic [BLOCK_W-1:0] mem_Writedata,
  output logic [BLOCK_W-1:0] mem_Readdata,
  output logic               mem_BusyWait
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, COOL} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [BLOCK_W-1:0]      data_q, data_d;
  logic                    busy_q, busy_d;
  logic [BLOCK_W-1:0]      rdata_q, rdata_d;
  logic                    commit;

  logic [BLOCK_W-1:0]      mem_array [DEPTH];

  // Upper block-address bits alias onto the same storage and are not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_Address[ADDR_W-1:DEPTH_LOG2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    data_d  = data_q;
    busy_d  = busy_q;
    rdata_d = rdata_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_Read || mem_Write) begin
          // A simultaneous read+write request is serviced as a write.
          wr_d    = mem_Write;
          idx_d   = mem_Address[DEPTH_LOG2-1:0];
          data_d  = mem_Writedata;
          busy_d  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          busy_d  = 1'b0;
          state_d = COOL;
          if (!wr_q) begin
            rdata_d = mem_array[idx_q];
          end
        end
      end
      COOL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage keeps its contents through reset; an aborted access never reaches commit.
  always_ff @(posedge clock) begin
    if (commit && wr_q) begin
      mem_array[idx_q] <= data_q;
    end
  end

  assign mem_Readdata = rdata_q;
  assign mem_BusyWait = busy_q;

endmodule

// File: tb/tb_data_memory_block.sv
// Self-checking bench for data_memory_block: directed corner cases followed by
// randomized block accesses checked against an array-based memory model.
module tb_data_memory_block;

  localparam int LAT = 5;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         mem_Read = 1'b0;
  logic         mem_Write = 1'b0;
  logic [27:0]  mem_Address = '0;
  logic [127:0] mem_Writedata = '0;
  logic [127:0] mem_Readdata;
  logic         mem_BusyWait;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] model_mem [256];
  bit           model_vld [256];
  logic [127:0] model_rdata = '0;
  int           written_idx [$];

  data_memory_block #(
    .ADDR_W(28), .BLOCK_W(128), .DEPTH_LOG2(8), .LATENCY(LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mem_Read(mem_Read),
    .mem_Write(mem_Write),
    .mem_Address(mem_Address),
    .mem_Writedata(mem_Writedata),
    .mem_Readdata(mem_Readdata),
    .mem_BusyWait(mem_BusyWait)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One complete access: request at a falling edge, dropped after acceptance,
  // then busy counted until it falls, then one cool-down cycle.
  task automatic access(input bit rd, input bit wr, input logic [27:0] addr,
                        input logic [127:0] data);
    int n;
    int idx;
    idx = int'(addr[7:0]);
    @(negedge clock);
    mem_Read = rd; mem_Write = wr; mem_Address = addr; mem_Writedata = data;
    @(negedge clock);
    // Garbage on the bus while busy must not influence the latched access.
    mem_Read = 1'b0; mem_Write = 1'b0;
    mem_Address = 28'($urandom); mem_Writedata = rand_block();
    n = 0;
    while (mem_BusyWait && n < 40) begin
      n++;
      if (wr) check_eq("rdata_hold_during_write", mem_Readdata, model_rdata);
      @(negedge clock);
    end
    check_eq("busy_cycles", 128'(n), 128'(LAT));
    if (wr) begin
      model_mem[idx] = data;
      if (!model_vld[idx]) written_idx.push_back(idx);
      model_vld[idx] = 1'b1;
    end else begin
      model_rdata = model_mem[idx];
    end
    check_eq(wr ? "rdata_after_write" : "rdata_after_read", mem_Readdata, model_rdata);
    $display("[TB] %s addr=%h busy=%0d rdata=%h", wr ? "WR" : "RD", addr, n, mem_Readdata);
    @(negedge clock);
  endtask

  initial begin
    int h, l, idx;
    logic [127:0] prior;

    // Reset held for two cycles.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("reset_busy", 128'(mem_BusyWait), 128'(0));
    check_eq("reset_rdata", mem_Readdata, 128'(0));
    reset = 1'b0;

    // Write then read back, then an aliased read.
    access(1'b0, 1'b1, 28'h0000005, 128'h0123456789ABCDEF0123456789ABCDEF);
    access(1'b1, 1'b0, 28'h0000005, '0);
    access(1'b1, 1'b0, 28'h0000105, '0);

    // Read and write together behave as a write; read data stays put.
    access(1'b1, 1'b1, 28'h0000007, {32{4'hA}});
    access(1'b1, 1'b0, 28'h0000007, '0);

    // Held read: each access is LATENCY busy cycles, then the COOL cycle and
    // the IDLE cycle that re-accepts the still-asserted request.
    @(negedge clock);
    mem_Read = 1'b1; mem_Address = 28'h0000005;
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      h = 0;
      while (mem_BusyWait && h < 40) begin h++; @(negedge clock); end
      check_eq("held_busy_cycles", 128'(h), 128'(LAT));
      model_rdata = model_mem[5];
      check_eq("held_rdata", mem_Readdata, model_rdata);
      if (k == 2) begin
        mem_Read = 1'b0;
      end else begin
        l = 0;
        while (!mem_BusyWait && l < 40) begin l++; @(negedge clock); end
        check_eq("held_idle_gap", 128'(l), 128'(2));
      end
      $display("[TB] HELD-RD #%0d busy=%0d rdata=%h", k, h, mem_Readdata);
    end
    @(negedge clock);

    // Reset in the third BUSY cycle aborts a pending write.
    prior = rand_block();
    access(1'b0, 1'b1, 28'h0000009, prior);
    @(negedge clock);
    mem_Write = 1'b1; mem_Address = 28'h0000009; mem_Writedata = {32{4'h5}};
    @(negedge clock);
    mem_Write = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_eq("busy_before_abort", 128'(mem_BusyWait), 128'(1));
    #1 reset = 1'b1;
    #1;
    check_eq("abort_busy", 128'(mem_BusyWait), 128'(0));
    check_eq("abort_rdata", mem_Readdata, 128'(0));
    model_rdata = '0;
    $display("[TB] RESET during write addr=%h busy=%0d", 28'h0000009, mem_BusyWait);
    @(negedge clock);
    reset = 1'b0;
    access(1'b1, 1'b0, 28'h0000009, '0);
    check_eq("abort_no_commit", mem_Readdata, prior);

    // Random traffic over a set of initialised indices with random alias bits.
    for (int i = 0; i < 12; i++) begin
      access(1'b0, 1'b1, {20'($urandom), 8'($urandom)}, rand_block());
    end
    for (int i = 0; i < 40; i++) begin
      int op;
      idx = written_idx[$urandom_range(written_idx.size() - 1)];
      op  = $urandom_range(3);
      access(op != 1, op >= 1, {20'($urandom), 8'(idx)}, rand_block());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
